ahb_burst_slave: RTL
====================

AHB_BURST_SLAVE -- requirements
Module: ahb_burst_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning bus width; legal values are 32 and 64.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of DATA_WIDTH words of storage.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, meaning fixed extra data-phase cycles per OKAY transfer; legal range is 0-15.
REQ-005 Port hclk  input  1: clock.
REQ-006 Port hresetn  input  1: reset, asynchronous, active-low.
REQ-007 Port hselx  input  1: slave select.
REQ-008 Port hreadyin  input  1: bus ready; the previous transfer on the bus is complete.
REQ-009 Port haddr  input  ADDR_WIDTH: byte address.
REQ-010 Port htrans  input  2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 Port hwrite  input  1: 1 = write.
REQ-012 Port hsize  input  3: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-013 Port hwdata  input  DATA_WIDTH: write data.
REQ-014 Port slv_busy  input  1: inserts a wait state while high.
REQ-015 Port hreadyout  output  1: data phase complete.
REQ-016 Port hresp  output  1: 0 = OKAY, 1 = ERROR.
REQ-017 Port hrdata  output  DATA_WIDTH: read data.

Function
REQ-018 An address phase SHALL be accepted at a hclk rising edge when hselx=1, hreadyin=1 and htrans[1]=1; haddr, hwrite and hsize are registered at that edge.
REQ-019 IDLE, BUSY or unselected cycles SHALL produce a zero-wait OKAY response (hreadyout=1, hresp=0) with no storage access.
REQ-020 The word index SHALL be haddr >> log2(DATA_WIDTH/8); the byte offset SHALL be the low log2(DATA_WIDTH/8) address bits.
REQ-021 An accepted transfer SHALL be an error when any of the following holds: word index >= MEM_DEPTH; 2^hsize > DATA_WIDTH/8; or the address is not aligned to 2^hsize.
REQ-022 The state machine SHALL have states ST_IDLE, ST_DATA and ST_ERR.
  - ST_IDLE -> ST_DATA on an accepted OKAY transfer.
  - ST_IDLE -> ST_ERR on an accepted error transfer.
  - ST_DATA completes when the wait counter is 0 and slv_busy=0; it then moves to ST_DATA, ST_ERR or ST_IDLE according to the transfer sampled on that same edge.
REQ-023 On entry to ST_DATA the wait counter SHALL load WAIT_STATES.
  - hreadyout=0 while the counter is nonzero or slv_busy=1.
  - The counter decrements once per cycle while nonzero.
  - slv_busy adds one cycle per high cycle, after the counter reaches 0.
REQ-024 ST_ERR SHALL drive a two-cycle response: cycle 1 hreadyout=0, hresp=1; cycle 2 hreadyout=1, hresp=1.
  - WAIT_STATES and slv_busy do not apply.
  - A transfer presented during cycle 2 is accepted normally.
REQ-025 A write SHALL update storage at the completing edge of its data phase, using only the byte lanes selected by hsize and the byte offset (little-endian); other lanes are unchanged.
REQ-026 An errored write SHALL never modify storage.
REQ-027 Read data SHALL be the full storage word at the registered index, driven on hrdata in the completing cycle (hreadyout=1) only.
  - hrdata=0 in all other cycles, including error responses and wait cycles.
REQ-028 A read whose address phase coincides with the data phase of a write to the same word SHALL return the post-write value (read-after-write coherence).
REQ-029 SEQ SHALL be handled identically to NONSEQ; the address is taken from haddr each beat.
REQ-030 BUSY inside a burst SHALL get a zero-wait OKAY response and SHALL NOT alter storage.
REQ-031 Storage SHALL hold MEM_DEPTH x DATA_WIDTH bits and SHALL NOT be cleared by reset.

Reset
REQ-032 While hresetn=0 the outputs SHALL be hreadyout=1, hresp=0, hrdata=0, with state ST_IDLE and wait counter 0.
REQ-033 Reset asserted mid data phase SHALL abort the transfer; a pending write does not modify storage.
REQ-034 After reset deassertion the first accepted transfer SHALL be handled per REQ-018.

Verification
REQ-035 Defaults, WAIT_STATES=0:
  - Stimulus: NONSEQ word write 0x10 = 0xDEADBEEF, then NONSEQ read 0x10.
  - Response: both zero-wait; hrdata=0xDEADBEEF in the read data phase.
REQ-036 Byte lanes:
  - Stimulus: word write 0x20 = 0x11223344, then byte write 0x21 with hwdata=0x0000AA00, then word read 0x20.
  - Response: hrdata=0x1122AA44.
REQ-037 Waits, WAIT_STATES=2:
  - Stimulus: write, with slv_busy=1 for one cycle after the counter expires.
  - Response: hreadyout low for exactly 3 cycles, then high; storage updated once.
REQ-038 Errors:
  - Stimulus: write to word index MEM_DEPTH (haddr=0x400), then a misaligned word read at 0x02.
  - Response: each gets the two-cycle ERROR response; storage unchanged; hrdata=0.
REQ-039 Back-to-back burst:
  - Stimulus: INCR4 word writes 0x40-0x4C, with BUSY inserted after beat 2, immediately followed by a read of 0x4C.
  - Response: the BUSY cycle gets OKAY zero-wait; the read returns the beat-4 data (read-after-write).
REQ-040 Reset mid-operation:
  - Stimulus: assert hresetn=0 during the data phase of a write to 0x30.
  - Response: outputs take reset values immediately; a subsequent read of 0x30 returns the pre-reset contents.

Source files
------------

// File: rtl/ahb_burst_slave_if.sv
// AHB-lite signal bundle between the bus fabric and ahb_burst_slave.
interface ahb_burst_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  hselx;
    logic                  hreadyin;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  slv_busy;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hselx, hreadyin, haddr, htrans, hwrite, hsize, hwdata, slv_busy,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hselx, hreadyin, haddr, htrans, hwrite, hsize, hwdata, slv_busy,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_burst_slave.sv
// AHB-lite memory slave with fixed wait states, busy stretching, byte-lane
// writes and a two-cycle ERROR response for out-of-range/illegal transfers.
module ahb_burst_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic             hclk,
    input  logic             hresetn,
    ahb_burst_slave_if.slave bus
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BYTE_BITS = $clog2(BYTES);
    localparam int IDX_W     = ADDR_WIDTH - BYTE_BITS;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic                 err2_q, err2_d;
    logic [MEM_AW-1:0]    idx_q;
    logic [BYTE_BITS-1:0] off_q;
    logic [2:0]           size_q;
    logic                 write_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                 accept;
    logic                 addr_err;
    logic                 load;
    logic                 done;
    logic                 ready;
    logic                 resp;
    logic [IDX_W-1:0]     idx_in;
    logic [BYTE_BITS-1:0] off_in;
    logic [BYTE_BITS-1:0] align_mask;
    logic [BYTES-1:0]     lane_en;

    assign accept     = bus.hselx & bus.hreadyin & bus.htrans[1];
    assign idx_in     = bus.haddr[ADDR_WIDTH-1:BYTE_BITS];
    assign off_in     = bus.haddr[BYTE_BITS-1:0];
    assign align_mask = BYTE_BITS'((32'd1 << bus.hsize) - 32'd1);
    assign addr_err   = (32'(idx_in) >= MEM_DEPTH)
                      || (32'(bus.hsize) > BYTE_BITS)
                      || ((off_in & align_mask) != '0);

    // Little-endian lane enables: 2^size bytes starting at the byte offset
    assign lane_en = BYTES'(((32'd1 << (32'd1 << size_q)) - 32'd1) << off_q);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            err2_q  <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err2_q  <= err2_d;
            if (load) begin
                idx_q   <= idx_in[MEM_AW-1:0];
                off_q   <= off_in;
                size_q  <= bus.hsize;
                write_q <= bus.hwrite;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err2_d  = 1'b0;
        load    = 1'b0;
        done    = 1'b0;
        ready   = 1'b1;
        resp    = 1'b0;

        case (state_q)
            ST_DATA: begin
                if (wait_q != '0) begin
                    ready  = 1'b0;
                    wait_d = wait_q - 4'd1;
                end else if (bus.slv_busy) begin
                    ready = 1'b0;
                end else begin
                    done = 1'b1;
                end
            end
            ST_ERR: begin
                resp   = 1'b1;
                ready  = err2_q;
                err2_d = ~err2_q;
            end
            default: ;
        endcase

        // The next address phase is only taken on the edge that ends this one
        if (ready) begin
            if (accept) begin
                load = 1'b1;
                if (addr_err) begin
                    state_d = ST_ERR;
                    err2_d  = 1'b0;
                end else begin
                    state_d = ST_DATA;
                    wait_d  = 4'(WAIT_STATES);
                end
            end else begin
                state_d = ST_IDLE;
                err2_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (done && write_q) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (lane_en[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hreadyout = ready;
    assign bus.hresp     = resp;
    assign bus.hrdata    = (done && !write_q) ? mem[idx_q] : '0;
endmodule
